// File: rtl/jtag_axi_fifo_arb.sv
// Round-robin arbiter that shares one jtag_axi FIFO between N_REQ requesters,
// with per-requester credit limits and a flush sequencer that clears FIFO and credits.
module jtag_axi_fifo_arb #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int QUOTA  = 2,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    fifo_write_o,
    output logic [ID_W+DATA_W-1:0]  fifo_data_o,
    input  logic                    fifo_full_i,
    output logic                    fifo_clear_o,
    input  logic                    pop_i,
    input  logic [ID_W-1:0]         pop_id_i,
    input  logic                    flush_i,
    output logic                    flush_done_o,
    output logic                    busy_o,
    output logic                    error_o
);

    localparam int CNT_W = $clog2(QUOTA + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    state_e           state_q;
    logic             live_q;
    logic             fifo_clear_q;
    logic             flush_done_q;
    logic             error_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  rr_ptr_d;
    logic [CNT_W-1:0] cnt_q [N_REQ];

    logic             run_ok;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] pop_hit;
    logic [N_REQ-1:0] credit_ret;
    logic [N_REQ-1:0] gnt_vec;
    logic             gnt_found;
    logic [ID_W-1:0]  gnt_id;
    logic             pop_err;

    // live_q holds grants off for the first cycle after reset release.
    assign run_ok = (state_q == ST_RUN) && live_q && !flush_i && !fifo_full_i;

    always_comb begin
        elig       = '0;
        pop_hit    = '0;
        credit_ret = '0;
        pop_err    = pop_i;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i]       = run_ok && req_valid_i[i] && (cnt_q[i] < CNT_W'(QUOTA));
            pop_hit[i]    = pop_i && (pop_id_i == ID_W'(i));
            credit_ret[i] = pop_hit[i] && (cnt_q[i] != '0);
            if (credit_ret[i]) begin
                pop_err = 1'b0;
            end
        end
    end

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!gnt_found && elig[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(idx);
            end
        end
    end

    assign gnt_vec  = gnt_found ? (N_REQ'(1) << gnt_id) : '0;
    assign rr_ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

    // NOTE: the small credit array is reset explicitly; it is state, not a storage RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            live_q       <= 1'b0;
            rr_ptr_q     <= '0;
            fifo_clear_q <= 1'b0;
            flush_done_q <= 1'b0;
            error_q      <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            live_q       <= 1'b1;
            fifo_clear_q <= 1'b0;
            flush_done_q <= 1'b0;
            error_q      <= 1'b0;
            if (gnt_found) begin
                rr_ptr_q <= rr_ptr_d;
            end
            case (state_q)
                ST_RUN: begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (gnt_vec[i] && !credit_ret[i]) begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end else if (!gnt_vec[i] && credit_ret[i]) begin
                            cnt_q[i] <= cnt_q[i] - 1'b1;
                        end
                    end
                    error_q <= pop_err;
                    if (flush_i) begin
                        state_q      <= ST_FLUSH;
                        fifo_clear_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    for (int i = 0; i < N_REQ; i++) begin
                        cnt_q[i] <= '0;
                    end
                    state_q      <= ST_DONE;
                    flush_done_q <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            busy_o = busy_o | (cnt_q[i] != '0);
        end
    end

    assign req_ready_o  = gnt_vec;
    assign fifo_write_o = gnt_found;
    assign fifo_data_o  = gnt_found ? {gnt_id, req_data_i[int'(gnt_id)*DATA_W +: DATA_W]} : '0;
    assign fifo_clear_o = fifo_clear_q;
    assign flush_done_o = flush_done_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_jtag_axi_fifo_arb.sv
// Scoreboard bench for jtag_axi_fifo_arb: directed stimulus queues expected FIFO
// writes, errors, clears and done pulses; a negedge monitor matches them by cycle.
module tb_jtag_axi_fifo_arb;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int QUOTA  = 2;
    localparam int ID_W   = 2;
    localparam int DW     = ID_W + DATA_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_write;
    logic [DW-1:0]           fifo_data;
    logic                    fifo_full;
    logic                    fifo_clear;
    logic                    pop;
    logic [ID_W-1:0]         pop_id;
    logic                    flush;
    logic                    flush_done;
    logic                    busy;
    logic                    error;

    jtag_axi_fifo_arb #(.N_REQ(N_REQ), .DATA_W(DATA_W), .QUOTA(QUOTA)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .fifo_write_o (fifo_write),
        .fifo_data_o  (fifo_data),
        .fifo_full_i  (fifo_full),
        .fifo_clear_o (fifo_clear),
        .pop_i        (pop),
        .pop_id_i     (pop_id),
        .flush_i      (flush),
        .flush_done_o (flush_done),
        .busy_o       (busy),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] pay [N_REQ];
    always_comb begin
        req_data = '0;
        for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = pay[i];
    end

    typedef enum int {EV_WRITE, EV_ERROR, EV_CLEAR, EV_DONE} ev_e;
    typedef struct {
        ev_e           kind;
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_e k, input int c, input logic [DW-1:0] d);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic exp_wr(input int c, input int id);
        push(EV_WRITE, c, {ID_W'(id), pay[id]});
    endtask

    task automatic observe(input ev_e k, input logic [DW-1:0] act);
        int hit;
        hit = -1;
        foreach (sbq[j]) if (hit < 0 && sbq[j].kind == k && sbq[j].cyc == cyc) hit = j;
        tests++;
        if (hit < 0) begin
            fails++;
            $display("FAIL %s: seen at cycle %0d data %0h, expected none", k.name(), cyc, act);
        end else begin
            if (k == EV_WRITE && act !== sbq[hit].data) begin
                fails++;
                $display("FAIL %s data: got %0h expected %0h (cycle %0d)", k.name(), act, sbq[hit].data, cyc);
            end
            sbq.delete(hit);
        end
    endtask

    // Monitor: flags expected events that never appeared, then matches what the DUT shows.
    always @(negedge clk) begin
        if (!rst) begin
            for (int j = sbq.size() - 1; j >= 0; j--) begin
                if (sbq[j].cyc < cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL %s missing: expected at cycle %0d data %0h, got nothing",
                             sbq[j].kind.name(), sbq[j].cyc, sbq[j].data);
                    sbq.delete(j);
                end
            end
            check("ready_vs_write", 64'(|req_ready), 64'(fifo_write));
            if (fifo_write) begin
                observe(EV_WRITE, fifo_data);
                check("ready_onehot", 64'(req_ready), 64'(4'b0001 << fifo_data[DW-1 -: ID_W]));
            end
            if (error)      observe(EV_ERROR, '0);
            if (fifo_clear) observe(EV_CLEAR, '0);
            if (flush_done) observe(EV_DONE, '0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_write"}, 64'(fifo_write), 64'd0);
        check({tag, "_data"},  64'(fifo_data), 64'd0);
        check({tag, "_clear"}, 64'(fifo_clear), 64'd0);
        check({tag, "_done"},  64'(flush_done), 64'd0);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
    endtask

    initial begin
        int c;
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        pop       = 1'b0;
        pop_id    = '0;
        flush     = 1'b0;
        for (int i = 0; i < N_REQ; i++) pay[i] = 32'hA5A5_0000 + 32'(i) * 32'h1111;

        // Reset with all requesters valid: nothing may come out.
        step();
        req_valid = 4'hF;
        step();
        check_all_zero("reset");
        rst = 1'b0;
        #1;
        check("first_cycle_ready", 64'(req_ready), 64'd0);

        // 1: all valid, no pops -> 0,1,2,3,0,1,2,3 then saturated.
        c = cyc;
        for (int k = 0; k < 8; k++) exp_wr(c + 1 + k, k % 4);
        repeat (9) step();
        check("t1_saturated_ready", 64'(req_ready), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            pop    = 1'b1;
            pop_id = ID_W'(k % 4);
            step();
        end
        pop = 1'b0;
        check("t1_drained_busy", 64'(busy), 64'd0);

        // 2: only requester 1; quota stall, pop resumes, grant+pop keeps count.
        req_valid = 4'b0010;
        c = cyc;
        exp_wr(c, 1);
        exp_wr(c + 1, 1);
        step();
        step();
        check("t2_quota_stall", 64'(req_ready), 64'd0);
        pop    = 1'b1;
        pop_id = 2'd1;
        step();
        exp_wr(cyc, 1);
        step();
        pop = 1'b0;
        exp_wr(cyc, 1);
        step();
        check("t2_simul_keeps_cnt", 64'(req_ready), 64'd0);
        req_valid = '0;
        pop       = 1'b1;
        pop_id    = 2'd1;
        step();
        step();
        pop = 1'b0;
        check("t2_drained_busy", 64'(busy), 64'd0);

        // 3: FIFO full blocks everything; release grants at rr_ptr (2).
        fifo_full = 1'b1;
        req_valid = 4'hF;
        #1;
        check("t3_full_ready", 64'(req_ready), 64'd0);
        check("t3_full_write", 64'(fifo_write), 64'd0);
        step();
        check("t3_full_ready2", 64'(req_ready), 64'd0);
        fifo_full = 1'b0;
        exp_wr(cyc, 2);
        step();
        req_valid = '0;

        // 4: build cnt = 1,0,2,1 then flush.
        req_valid = 4'b1101;
        c = cyc;
        exp_wr(c, 3);
        exp_wr(c + 1, 0);
        exp_wr(c + 2, 2);
        repeat (3) step();
        check("t4_busy_before", 64'(busy), 64'd1);
        req_valid = 4'hF;
        flush     = 1'b1;
        step();
        flush  = 1'b0;
        push(EV_CLEAR, cyc, '0);
        pop    = 1'b1;
        pop_id = 2'd1;
        step();
        pop = 1'b0;
        push(EV_DONE, cyc, '0);
        check("t4_busy_after_flush", 64'(busy), 64'd0);
        step();
        exp_wr(cyc, 3);
        step();
        req_valid = '0;

        // 5: pop on a zero credit count -> one error pulse, no wrap.
        pop    = 1'b1;
        pop_id = 2'd2;
        push(EV_ERROR, cyc + 1, '0);
        step();
        pop_id = 2'd3;
        step();
        pop = 1'b0;
        check("t5_no_wrap_busy", 64'(busy), 64'd0);
        step();

        // 6: reset during FLUSH aborts without a done pulse.
        req_valid = 4'hF;
        exp_wr(cyc, 0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        push(EV_CLEAR, cyc, '0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        step();
        step();
        rst = 1'b0;
        #1;
        check("t6_first_cycle_ready", 64'(req_ready), 64'd0);
        c = cyc;
        exp_wr(c + 1, 0);
        exp_wr(c + 2, 1);
        repeat (3) step();
        req_valid = '0;
        repeat (3) step();

        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
